// File: rtl/cpu_pkg.sv
// Shared core types: PC/instruction widths and the fetch packet handed to decode.
package cpu_pkg;
  localparam int PC_W    = 14;
  localparam int INSTR_W = 32;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_queue2.sv
// Two-entry FIFO of fetch packets; clear wins over push, push into a full
// queue is accepted only when a pop frees a slot in the same cycle.
module fetch_queue2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  fetch_pkt_t din,
  output fetch_pkt_t head,
  output logic [1:0] count
);

  fetch_pkt_t mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited reads to a 1-cycle synchronous memory,
// 2-entry return queue and ALU/decode redirect handling.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 14'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b_is_hazard,
  input  logic [PC_W-1:0]    b_addr,
  input  logic               j_req,
  input  logic [PC_W-1:0]    j_addr,
  input  logic               dec_ready,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               flush
);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] target;
  logic            inflight;
  logic            redirect;
  logic            kill;
  logic            pop;
  logic            push;
  logic            issue;
  logic [1:0]      count;
  logic [2:0]      occupancy;
  logic [2:0]      limit;
  fetch_pkt_t      head;
  fetch_pkt_t      wr_pkt;

  assign redirect = ~rst & (b_is_hazard | j_req);
  assign target   = b_is_hazard ? b_addr : j_addr;

  // With 1-cycle memory latency the read being killed is the one whose data
  // arrives in the redirect cycle itself, so the discard is applied here.
  assign kill     = redirect;

  assign if_valid = ~rst & ~redirect & (count != 2'd0);
  assign pop      = if_valid & dec_ready;
  assign flush    = ~rst & b_is_hazard;

  // Words already owned (queued + in flight) must fit in the queue after pop.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign limit     = 3'd2 + {2'b00, pop};
  assign issue     = ~rst & (redirect | (occupancy < limit));

  assign imem_en   = issue;
  assign imem_addr = rst ? RESET_PC : (redirect ? target : fetch_pc);

  assign push      = inflight & ~kill;
  assign wr_pkt    = '{pc: inflight_pc, instr: imem_data};

  assign if_pc     = rst ? '0 : head.pc;
  assign if_instr  = rst ? '0 : head.instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= imem_addr + PC_W'(1);
        inflight_pc <= imem_addr;
      end
    end
  end

  fetch_queue2 u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (wr_pkt),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: stream-level reference model plus directed literal checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        b_is_hazard;
  logic [13:0] b_addr;
  logic        j_req;
  logic [13:0] j_addr;
  logic        dec_ready;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [13:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;

  logic        imem_en2;
  logic [13:0] imem_addr2;
  logic [31:0] imem_data2;
  logic        if_valid2;
  logic [13:0] if_pc2;
  logic [31:0] if_instr2;
  logic        flush2;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .b_is_hazard(b_is_hazard), .b_addr(b_addr),
    .j_req(j_req), .j_addr(j_addr), .dec_ready(dec_ready),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
  );

  fetch_unit #(.RESET_PC(14'h3FFE)) dut_wrap (
    .clk(clk), .rst(rst), .b_is_hazard(1'b0), .b_addr(14'h0000),
    .j_req(1'b0), .j_addr(14'h0000), .dec_ready(dec_ready),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2), .flush(flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns instr == pc one cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    imem_data  <= imem_en  ? {18'h0, imem_addr}  : 32'hBAD0_0000;
    imem_data2 <= imem_en2 ? {18'h0, imem_addr2} : 32'hBAD0_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: after a (re)start at cycle S, words are valid from S+2 on,
  // consecutive PCs, advancing only on acceptance; redirect cycles show nothing.
  int          cyc    = 0;
  int          start  = 0;
  logic [13:0] exp_pc = 14'h0;
  logic        saw_40 = 1'b0;

  always @(negedge clk) begin
    logic redir;
    logic vexp;
    redir = b_is_hazard | j_req;
    if (rst) begin
      chk("rst_valid", {31'h0, if_valid}, 32'h0);
      chk("rst_imem_en", {31'h0, imem_en}, 32'h0);
      chk("rst_imem_addr", {18'h0, imem_addr}, 32'h0);
      chk("rst_pc", {18'h0, if_pc}, 32'h0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_flush", {31'h0, flush}, 32'h0);
      start  = cyc + 1;
      exp_pc = 14'h0000;
    end else begin
      vexp = !redir && (cyc >= start + 2);
      chk("valid", {31'h0, if_valid}, {31'h0, vexp});
      chk("flush", {31'h0, flush}, {31'h0, b_is_hazard});
      if (vexp) begin
        chk("pc", {18'h0, if_pc}, {18'h0, exp_pc});
        chk("instr", if_instr, {18'h0, exp_pc});
        if (dec_ready) exp_pc = exp_pc + 14'd1;
      end
      if (redir) begin
        exp_pc = b_is_hazard ? b_addr : j_addr;
        start  = cyc;
        chk("redir_en", {31'h0, imem_en}, 32'h1);
        chk("redir_addr", {18'h0, imem_addr}, {18'h0, exp_pc});
      end
      if (if_valid && if_pc == 14'h0040) saw_40 = 1'b1;
    end
    cyc++;
  end

  initial begin
    logic [15:0] pat;
    logic [13:0] wrap_seq [4];
    pat = 16'b1011_0011_1110_0101;
    wrap_seq[0] = 14'h3FFE; wrap_seq[1] = 14'h3FFF;
    wrap_seq[2] = 14'h0000; wrap_seq[3] = 14'h0001;

    rst = 1'b1; b_is_hazard = 1'b0; b_addr = '0; j_req = 1'b0; j_addr = '0;
    dec_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;                                   // cycle R+1
    @(negedge clk);
    chk("first_read_en", {31'h0, imem_en}, 32'h1);
    chk("first_read_addr", {18'h0, imem_addr}, 32'h0);
    tick(); tick();                               // R+3
    @(negedge clk);
    chk("first_valid", {31'h0, if_valid}, 32'h1);
    chk("first_pc", {18'h0, if_pc}, 32'h0);
    chk("wrap_pc0", {18'h0, if_pc2}, {18'h0, wrap_seq[0]});
    for (int i = 1; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("wrap_pc", {18'h0, if_pc2}, {18'h0, wrap_seq[i]});
      chk("seq_pc", {18'h0, if_pc}, i);
    end

    tick();                                       // R+7, pc 4
    tick();                                       // R+8, pc 5
    dec_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_pc", {18'h0, if_pc}, 32'd5);
      chk("stall_valid", {31'h0, if_valid}, 32'h1);
      chk("stall_imem_en", {31'h0, imem_en}, 32'h0);
      tick();
    end
    dec_ready = 1'b1;
    @(negedge clk);
    chk("release_pc5", {18'h0, if_pc}, 32'd5);
    tick();
    @(negedge clk);
    chk("release_pc6", {18'h0, if_pc}, 32'd6);

    for (int i = 0; i < 16; i++) begin
      tick();
      dec_ready = pat[i];
    end
    tick(); dec_ready = 1'b0;
    tick(); tick();
    b_is_hazard = 1'b1; b_addr = 14'h0100;        // queue full, T
    @(negedge clk);
    chk("hz_flush", {31'h0, flush}, 32'h1);
    chk("hz_valid", {31'h0, if_valid}, 32'h0);
    tick();
    b_is_hazard = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    chk("hz_t1_valid", {31'h0, if_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("hz_t2_pc", {18'h0, if_pc}, 32'h100);
    tick();
    @(negedge clk);
    chk("hz_t3_pc", {18'h0, if_pc}, 32'h101);

    repeat (3) tick();
    b_is_hazard = 1'b1; b_addr = 14'h0200; j_req = 1'b1; j_addr = 14'h0040;
    saw_40 = 1'b0;
    @(negedge clk);
    chk("both_flush", {31'h0, flush}, 32'h1);
    tick();
    b_is_hazard = 1'b0; j_req = 1'b0;
    tick();
    @(negedge clk);
    chk("both_pc", {18'h0, if_pc}, 32'h200);
    repeat (8) tick();
    @(negedge clk);
    chk("no_j_target", {31'h0, saw_40}, 32'h0);

    tick();
    j_req = 1'b1; j_addr = 14'h3FFE;
    @(negedge clk);
    chk("j_flush", {31'h0, flush}, 32'h0);
    tick();
    j_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("j_wrap_pc", {18'h0, if_pc}, {18'h0, wrap_seq[i]});
    end

    tick();
    dec_ready = 1'b0; rst = 1'b1;                 // read in flight, stalled
    @(negedge clk);
    chk("midrst_valid", {31'h0, if_valid}, 32'h0);
    tick();
    rst = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {31'h0, if_valid}, 32'h0);
    chk("post_rst_addr", {18'h0, imem_addr}, 32'h0);
    tick();
    @(negedge clk);
    chk("post_rst_drop", {31'h0, if_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("restart_pc0", {18'h0, if_pc}, 32'h0);
    chk("restart_valid", {31'h0, if_valid}, 32'h1);
    tick();
    @(negedge clk);
    chk("restart_pc1", {18'h0, if_pc}, 32'h1);

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
